// File: rtl/regfile_pkg.sv
// Shared types and the pending-counter next-state helper for regfile_scoreboard.
// Counter width is carried at PEND_W_MAX bits; only the low CNT_W bits are ever nonzero.
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NREGS_DEF  = 4;
  localparam int CNT_W_DEF  = 2;
  localparam int PEND_W_MAX = 8;

  typedef logic [PEND_W_MAX-1:0] pend_t;

  typedef struct packed {
    pend_t cnt;
    logic  uflow;
  } pend_next_t;

  // Saturating up/down step; a decrement at zero holds the count and flags underflow.
  function automatic pend_next_t next_pend(input pend_t cur, input logic inc,
                                           input logic dec, input pend_t max);
    pend_next_t res;
    res.cnt   = cur;
    res.uflow = dec && (cur == {PEND_W_MAX{1'b0}});
    case ({inc, dec})
      2'b10:   res.cnt = (cur != max) ? cur + pend_t'(1) : cur;
      2'b01:   res.cnt = (cur != {PEND_W_MAX{1'b0}}) ? cur - pend_t'(1) : cur;
      default: res.cnt = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// One per-register pending-write counter: saturating up on reserve, down on write-back.
module pend_counter
  import regfile_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  inc,
  input  logic  dec,
  output pend_t cnt,
  output logic  uflow
);

  localparam pend_t PEND_MAX = pend_t'((32'd1 << CNT_W) - 32'd1);

  pend_next_t nxt_s;
  pend_t      cnt_r;

  // Next count and underflow detect from the current count.
  always_comb begin
    nxt_s = next_pend(cnt_r, inc, dec, PEND_MAX);
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {PEND_W_MAX{1'b0}};
    end else begin
      cnt_r <= nxt_s.cnt;
    end
  end

  assign cnt   = cnt_r;
  assign uflow = nxt_s.uflow;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard and hazard flags.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data onto the read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              hazard1,
  output logic              hazard2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ready,
  output logic              err
);

  localparam pend_t PEND_MAX  = pend_t'((32'd1 << CNT_W) - 32'd1);
  localparam pend_t PEND_ZERO = pend_t'(0);
  localparam pend_t PEND_ONE  = pend_t'(1);

  logic [DATA_W-1:0] regs_r [NREGS];
  pend_t             pend_s [NREGS];
  logic [NREGS-1:0]  inc_s;
  logic [NREGS-1:0]  dec_s;
  logic [NREGS-1:0]  uflow_s;
  logic              rsv_acc_s;
  logic              err_r;

  // A same-cycle write to the reserved register frees the slot it needs.
  always_comb begin
    rsv_ready = (pend_s[rsv_addr] != PEND_MAX) || (wr_en && (wr_addr == rsv_addr));
    rsv_acc_s = rsv_en && rsv_ready;
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_pend
    assign inc_s[i] = rsv_acc_s && (rsv_addr == ADDR_W'(i));
    assign dec_s[i] = wr_en && (wr_addr == ADDR_W'(i));

    pend_counter #(.CNT_W(CNT_W)) u_pend (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (inc_s[i]),
      .dec     (dec_s[i]),
      .cnt     (pend_s[i]),
      .uflow   (uflow_s[i])
    );
  end

  // Data array; write-back lands unconditionally, even on underflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Sticky underflow error, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if (|uflow_s) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;

  // Read muxes and hazard flags, with optional write-back forwarding.
  always_comb begin
    rd_data1 = regs_r[rd_addr1];
    rd_data2 = regs_r[rd_addr2];
    hazard1  = (pend_s[rd_addr1] != PEND_ZERO);
    hazard2  = (pend_s[rd_addr2] != PEND_ZERO);
`ifdef REGFILE_BYPASS_EN
    // Forwarding hides the hazard only when this write retires the last reservation.
    if (wr_en && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      hazard1  = hazard1 && !((pend_s[rd_addr1] == PEND_ONE) && !inc_s[rd_addr1]);
    end else begin
      rd_data1 = regs_r[rd_addr1];
    end
    if (wr_en && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
      hazard2  = hazard2 && !((pend_s[rd_addr2] == PEND_ONE) && !inc_s[rd_addr2]);
    end else begin
      rd_data2 = regs_r[rd_addr2];
    end
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against a behavioural model.
// Honours REGFILE_BYPASS_EN in the model when the design is built with it.
module tb_regfile_scoreboard;

  localparam int DATA_W = 16;
  localparam int NREGS  = 4;
  localparam int CNT_W  = 2;
  localparam int ADDR_W = 2;
  localparam int PMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [ADDR_W-1:0] rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, rsv_addr = '0;
  logic [DATA_W-1:0] rd_data1, rd_data2, wr_data = '0;
  logic              hazard1, hazard2, rsv_ready, err;
  logic              wr_en = 1'b0, rsv_en = 1'b0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DATA_W), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .hazard1(hazard1), .hazard2(hazard2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .err(err)
  );

  int checks = 0;
  int failures = 0;

  int unsigned regs_m [NREGS];
  int          pend_m [NREGS];
  bit          err_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin
      regs_m[i] = 0;
      pend_m[i] = 0;
    end
    err_m = 1'b0;
  endfunction

  function automatic bit ready_m();
    return (pend_m[rsv_addr] != PMAX) || (wr_en && wr_addr == rsv_addr);
  endfunction

  function automatic bit hazard_m(input int ra);
    bit acc;
    acc = rsv_en && ready_m();
    if (pend_m[ra] == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == ra && pend_m[ra] == 1 && !(acc && rsv_addr == ra)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic int unsigned data_m(input int ra);
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == ra) return wr_data;
`endif
    return regs_m[ra];
  endfunction

  task automatic set_in(input bit we, input int wa, input int wd, input bit re, input int ra,
                        input int a1, input int a2);
    wr_en = we; wr_addr = ADDR_W'(wa); wr_data = DATA_W'(wd);
    rsv_en = re; rsv_addr = ADDR_W'(ra);
    rd_addr1 = ADDR_W'(a1); rd_addr2 = ADDR_W'(a2);
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".rd1"}, 32'(rd_data1), data_m(rd_addr1));
    check_eq({tag, ".rd2"}, 32'(rd_data2), data_m(rd_addr2));
    check_eq({tag, ".hz1"}, 32'(hazard1), 32'(hazard_m(rd_addr1)));
    check_eq({tag, ".hz2"}, 32'(hazard2), 32'(hazard_m(rd_addr2)));
    check_eq({tag, ".rdy"}, 32'(rsv_ready), 32'(ready_m()));
    check_eq({tag, ".err"}, 32'(err), 32'(err_m));
  endtask

  // Check outputs for the current inputs, take one clock edge, advance the model.
  task automatic step(input string tag);
    bit acc;
    #1;
    check_outputs(tag);
    acc = rsv_en && ready_m();
    @(posedge clk);
    if (wr_en) begin
      regs_m[wr_addr] = wr_data;
      if (pend_m[wr_addr] == 0) err_m = 1'b1;
    end
    if (!(wr_en && acc && wr_addr == rsv_addr)) begin
      if (wr_en && pend_m[wr_addr] > 0) pend_m[wr_addr]--;
      if (acc) pend_m[rsv_addr]++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int a1, input int a2);
    set_in(1'b0, 0, 0, 1'b0, 0, a1, a2);
    #1;
  endtask

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    #10;
    check_outputs("reset");
    check_eq("reset.rdy_const", 32'(rsv_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int a = 0; a < NREGS; a++) begin
      set_in(1'b0, 0, 0, 1'b0, a, a, NREGS - 1 - a);
      step("rd_all");
    end

    set_in(1'b1, 2, 16'hBEEF, 1'b0, 0, 2, 0);
    step("wr_beef");
    idle(2, 0);
    check_eq("beef_next", 32'(rd_data1), 32'h0000BEEF);

    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 0, 0, 1'b1, 1, 1, 0);
      step("rsv_r1");
      if (k == 2) begin
        idle(1, 0);
        rsv_addr = ADDR_W'(1);
        #1;
        check_eq("r1_full_hz", 32'(hazard1), 32'd1);
        check_eq("r1_full_rdy", 32'(rsv_ready), 32'd0);
        set_in(1'b0, 0, 0, 1'b1, 1, 1, 0);
      end
    end
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1, 16'h1000 + k, 1'b0, 0, 1, 0);
      step("wr_r1");
      idle(1, 0);
      check_eq("r1_drain_hz", 32'(hazard1), (k == 2) ? 32'd0 : 32'd1);
    end

    set_in(1'b0, 0, 0, 1'b1, 3, 3, 0);
    step("rsv_r3");
    set_in(1'b1, 3, 16'h1234, 1'b1, 3, 3, 0);
    step("rsv_wr_r3");
    idle(3, 0);
    check_eq("r3_hz", 32'(hazard1), 32'd1);
    check_eq("r3_data", 32'(rd_data1), 32'h00001234);
    set_in(1'b1, 3, 16'h4321, 1'b0, 0, 3, 0);
    step("wr_r3");

    set_in(1'b1, 0, 16'h5555, 1'b0, 0, 0, 1);
    step("uflow_r0");
    idle(0, 1);
    check_eq("err_set", 32'(err), 32'd1);
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 0, 0, 1'b1, k % NREGS, 0, 1);
      step("err_hold");
    end
    idle(0, 1);
    check_eq("err_held", 32'(err), 32'd1);

    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, 0, 0, 1'b1, 2, 2, 2);
      step("rsv_r2");
    end
    idle(2, 2);
    check_eq("pre_rst_hz", 32'(hazard1), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_hz", 32'(hazard1), 32'd0);
    check_eq("async_rd", 32'(rd_data1), 32'd0);
    check_eq("async_err", 32'(err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(99) < 40, $urandom_range(NREGS - 1), $urandom,
             $urandom_range(99) < 60, $urandom_range(NREGS - 1),
             $urandom_range(NREGS - 1), $urandom_range(NREGS - 1));
      step("rand");
      if (n == 200) begin
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rand_rst");
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
